serial_slave_port: RTL and testbench

- Slave-side responder for the serial system bus.
- Connects to one slave port of the bus arbiter (mode, wr_bus, master_valid, master_ready in; rd_bus, slave_ready, slave_valid out).
- Deserialises an in-slave word address and write data, and commits writes to a local memory.
- Serialises read data back to the master. Optional split signalling covers long read latency.

---
 rtl/serial_slave_port_if.sv | 22 ++
 rtl/serial_slave_port.sv | 156 +++++++++++++++
 tb/tb_serial_slave_port.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_slave_port_if.sv
// Serial system bus, slave-port side: in-bits from the master, read bits and
// flow control back from the slave.
interface serial_slave_port_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic rd_bus;
  logic slave_ready;
  logic slave_valid;
  logic split;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  rd_bus, slave_ready, slave_valid, split
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output rd_bus, slave_ready, slave_valid, split
  );
endinterface

// File: rtl/serial_slave_port.sv
// Serial bus slave: deserialises address/write data into a local memory and
// serialises read data back, with optional split signalling during read latency.
module serial_slave_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 4,
  parameter int SPLIT_EN     = 0
) (
  input logic clk,
  input logic rst,
  serial_slave_port_if.slave bus
);

  localparam int LAT   = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int MAXC0 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAXC  = (MAXC0 > LAT) ? MAXC0 : LAT;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]    LAT_LAST  = CNT_W'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RLAT, S_RDATA
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    mode_q, mode_d;
  logic                    slave_ready_q, slave_ready_d;
  logic                    slave_valid_q, slave_valid_d;
  logic                    split_q, split_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                    in_xfer, out_xfer, in_range, mem_we;
  logic [IDX_W-1:0]        idx;

  assign in_xfer  = bus.master_valid && slave_ready_q;
  assign out_xfer = slave_valid_q && bus.master_ready;
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign idx      = addr_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          mode_d = bus.mode;
          addr_d = ADDR_WIDTH'(bus.wr_bus);
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = bus.mode ? S_WDATA : S_RLAT;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (in_xfer) begin
          addr_d = (addr_q << 1) | ADDR_WIDTH'(bus.wr_bus);
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_WDATA : S_RLAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WDATA: begin
        if (in_xfer) begin
          data_d = (data_q << 1) | DATA_WIDTH'(bus.wr_bus);
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        // Out-of-range addresses are dropped without any error indication.
        mem_we  = in_range;
        state_d = S_IDLE;
      end
      S_RLAT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          data_d  = in_range ? mem[idx] : '0;
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDATA: begin
        if (out_xfer) begin
          data_d = data_q << 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags are registered from the next state so they read 0 throughout reset.
    slave_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    slave_valid_d = (state_d == S_RDATA);
    split_d       = (SPLIT_EN != 0) && (state_d == S_RLAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      mode_q        <= 1'b0;
      slave_ready_q <= 1'b0;
      slave_valid_q <= 1'b0;
      split_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      slave_ready_q <= slave_ready_d;
      slave_valid_q <= slave_valid_d;
      split_q       <= split_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= data_q;
  end

  assign bus.rd_bus      = slave_valid_q & data_q[DATA_WIDTH-1];
  assign bus.slave_ready = slave_ready_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.split       = split_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Two slaves share the master-side inputs: A (latency 4, no split) and
// B (latency 6, split enabled), both with a 32-word memory.
module tb_serial_slave_port;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  serial_slave_port_if ifa ();
  serial_slave_port_if ifb ();

  assign ifb.mode         = ifa.mode;
  assign ifb.wr_bus       = ifa.wr_bus;
  assign ifb.master_valid = ifa.master_valid;
  assign ifb.master_ready = ifa.master_ready;

  serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(32),
                      .READ_LATENCY(4), .SPLIT_EN(0)) u_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));

  serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(32),
                      .READ_LATENCY(6), .SPLIT_EN(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] ref_mem [32];

  function automatic logic [7:0] model_rd(input logic [11:0] a);
    return (a < 12'd32) ? ref_mem[a[4:0]] : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Drive address (and data for writes) MSB first; returns at the negedge on
  // which the last requested transfer is set up.
  task automatic send_bits(input bit is_wr, input logic [11:0] addr, input logic [7:0] data,
                           input bit gaps, input int nstop);
    logic [19:0] fv;
    int n;
    int idx;
    int cyc;
    bit mv;
    fv  = {addr, data};
    n   = is_wr ? 20 : 12;
    if (nstop < n) n = nstop;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mv = gaps ? (cyc % 2 == 0) : 1'b1;
      ifa.master_valid = mv;
      ifa.wr_bus       = mv ? fv[19 - idx] : 1'($urandom);
      ifa.mode         = (idx == 0) ? is_wr : ~is_wr;
      if (mv && ifa.slave_ready) idx++;
    end
    if (idx < n) timeout("send_bits");
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input bit gaps);
    send_bits(1'b1, addr, data, gaps, 99);
    @(negedge clk);
    ifa.master_valid = 1'b0;
    chk("write_cycle_rdy_a", ifa.slave_ready, 0);
    chk("write_cycle_rdy_b", ifb.slave_ready, 0);
    @(negedge clk);
    chk("after_write_rdy_a", ifa.slave_ready, 1);
    chk("after_write_rdy_b", ifb.slave_ready, 1);
    if (addr < 12'd32) ref_mem[addr[4:0]] = data;
  endtask

  task automatic do_read(input logic [11:0] addr, input bit gaps, input bit bp,
                         input logic [7:0] exp, input string tag);
    logic [7:0] dat [2];
    int   nb [2];
    int   lat [2];
    int   spc [2];
    int   st [2];
    bit   hold [2];
    logic hb [2];
    logic vv [2];
    logic rb [2];
    logic sp [2];
    logic sr [2];
    bit   mr;
    bit   fin;
    send_bits(1'b0, addr, 8'h00, gaps, 99);
    for (int d = 0; d < 2; d++) begin
      dat[d] = 8'h00; nb[d] = 0; lat[d] = -1; spc[d] = 0; st[d] = 0; hold[d] = 0; hb[d] = 1'b0;
    end
    fin = 1'b0;
    for (int k = 1; k <= 300 && !fin; k++) begin
      @(negedge clk);
      ifa.master_valid = 1'b0;
      mr = bp ? (k % 2 == 1) : 1'b1;
      ifa.master_ready = mr;
      vv[0] = ifa.slave_valid; rb[0] = ifa.rd_bus; sp[0] = ifa.split; sr[0] = ifa.slave_ready;
      vv[1] = ifb.slave_valid; rb[1] = ifb.rd_bus; sp[1] = ifb.split; sr[1] = ifb.slave_ready;
      for (int d = 0; d < 2; d++) begin
        if (st[d] == 1) begin
          chk({tag, "_vld_drop"}, vv[d], 0);
          chk({tag, "_rdy_back"}, sr[d], 1);
          st[d] = 2;
        end else if (st[d] == 0) begin
          if (sp[d]) spc[d]++;
          if (vv[d] && lat[d] < 0) begin
            lat[d] = k;
            chk({tag, "_split_at_vld"}, sp[d], 0);
          end
          if (hold[d]) chk({tag, "_rd_hold"}, rb[d], hb[d]);
          hold[d] = 1'b0;
          if (vv[d]) begin
            if (mr) begin
              dat[d] = {dat[d][6:0], rb[d]};
              nb[d]++;
              if (nb[d] == 8) st[d] = 1;
            end else begin
              hold[d] = 1'b1;
              hb[d]   = rb[d];
            end
          end
        end
      end
      fin = (st[0] == 2) && (st[1] == 2);
    end
    if (!fin) timeout({tag, "_read"});
    chk({tag, "_data_a"}, dat[0], exp);
    chk({tag, "_data_b"}, dat[1], exp);
    chk({tag, "_lat_a"}, lat[0], 5);
    chk({tag, "_lat_b"}, lat[1], 7);
    chk({tag, "_split_a"}, spc[0], 0);
    chk({tag, "_split_b"}, spc[1], 6);
  endtask

  typedef struct {
    bit         wr;
    logic [11:0] addr;
    logic [7:0]  data;
    bit         gaps;
    bit         bp;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [14];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vt[0]  = '{1'b1, 12'h012, 8'hA5, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 12'h012, 8'h00, 1'b0, 1'b0, 8'hA5};
    vt[2]  = '{1'b1, 12'h005, 8'h3C, 1'b1, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 12'h005, 8'h00, 1'b1, 1'b1, 8'h3C};
    vt[4]  = '{1'b0, 12'h012, 8'h00, 1'b0, 1'b1, 8'hA5};
    vt[5]  = '{1'b1, 12'h020, 8'hFF, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b0, 12'h020, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 8'h5A};
    vt[8]  = '{1'b1, 12'hFFF, 8'h12, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 12'hFFF, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[10] = '{1'b0, 12'h01F, 8'h00, 1'b0, 1'b0, 8'h45};
    vt[11] = '{1'b1, 12'h01F, 8'h00, 1'b1, 1'b0, 8'h00};
    vt[12] = '{1'b0, 12'h01F, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[13] = '{1'b0, 12'h005, 8'h00, 1'b0, 1'b0, 8'h3C};

    rst = 1'b1;
    ifa.mode = 1'b0;
    ifa.wr_bus = 1'b0;
    ifa.master_valid = 1'b0;
    ifa.master_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_bus_a", ifa.rd_bus, 0);
    chk("rst_vld_a", ifa.slave_valid, 0);
    chk("rst_split_a", ifa.split, 0);
    chk("rst_rdy_a", ifa.slave_ready, 0);
    chk("rst_rd_bus_b", ifb.rd_bus, 0);
    chk("rst_vld_b", ifb.slave_valid, 0);
    chk("rst_split_b", ifb.split, 0);
    chk("rst_rdy_b", ifb.slave_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_a", ifa.slave_ready, 1);
    chk("post_rst_rdy_b", ifb.slave_ready, 1);

    // Preload every word so all later reads have defined contents.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] pv;
      pv = 8'(i) ^ 8'h5A;
      do_write(12'(i), pv, 1'(i % 2));
    end

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].gaps);
      else          do_read(vt[i].addr, vt[i].gaps, vt[i].bp, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a write frame must leave memory untouched.
    do_write(12'h004, 8'h11, 1'b0);
    send_bits(1'b1, 12'h004, 8'h77, 1'b0, 17);
    @(negedge clk);
    ifa.master_valid = 1'b0;
    chk("pre_rst_rdy_a", ifa.slave_ready, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rd_bus_a", ifa.rd_bus, 0);
    chk("midrst_vld_a", ifa.slave_valid, 0);
    chk("midrst_split_a", ifa.split, 0);
    chk("midrst_rdy_a", ifa.slave_ready, 0);
    chk("midrst_rd_bus_b", ifb.rd_bus, 0);
    chk("midrst_vld_b", ifb.slave_valid, 0);
    chk("midrst_split_b", ifb.split, 0);
    chk("midrst_rdy_b", ifb.slave_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_rdy_a", ifa.slave_ready, 1);
    chk("midrst_release_rdy_b", ifb.slave_ready, 1);
    do_read(12'h004, 1'b0, 1'b0, 8'h11, "rst_rd");

    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      logic [7:0]  dv;
      bit          w;
      a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 47));
      dv = 8'($urandom);
      w  = 1'($urandom_range(0, 1));
      if (w) do_write(a, dv, 1'($urandom_range(0, 1)));
      else   do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), model_rd(a), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
